modexp_ctrl: RTL and testbench
==============================

Name: modexp_ctrl

Overview:
- Sequencing controller for RSA decryption, m = c^d mod n, using left-to-right binary square-and-multiply.
- Latches the modulus, private key and ciphertext (n, d, c) from the number store on a start pulse.
- Drives one shared external modular multiplier through a start/done handshake and returns plaintext m with a done pulse.

Parameters:
- WIDTH, 32, operand width of n, d, c, m and multiplier operands.
- TIMEOUT, 1024, max cycles to wait for mul_done before aborting with error.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- start  input  1  one-cycle request; sampled only in IDLE
- n  input  WIDTH  modulus
- d  input  WIDTH  private exponent
- c  input  WIDTH  ciphertext
- busy  output  1  high from the cycle after an accepted start until the done cycle inclusive
- done  output  1  one-cycle pulse, m/error valid
- error  output  1  set with done on n==0 or multiplier timeout; held until next accepted start
- m  output  WIDTH  result, held until next accepted start
- mul_start  output  1  one-cycle pulse launching a multiply
- mul_a  output  WIDTH  multiplier operand A
- mul_b  output  WIDTH  multiplier operand B
- mul_mod  output  WIDTH  modulus for multiplier (= latched n)
- mul_done  input  1  one-cycle pulse from multiplier
- mul_result  input  WIDTH  (mul_a*mul_b) mod mul_mod, valid when mul_done=1; multiplier fully reduces any operands < 2^WIDTH

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; busy, done, error, mul_start=0; m, mul_a, mul_b, mul_mod=0; watchdog=0. Reset mid-operation aborts immediately. No done is produced. A mul_done arriving after reset is ignored.
- Registers: n_r, d_r, c_r, r (accumulator), idx (log2(WIDTH) bits), wd (watchdog counter).
- IDLE: on start=1, latch n, d, c into n_r, d_r, c_r, then r=1, idx=WIDTH-1, error=0, go LOAD. start in any other state is ignored.
- LOAD (1 cycle), checks in priority order:
  - n_r==0: m=0, error=1, go DONE.
  - n_r==1: m=0, go DONE.
  - d_r==0: m=1, go DONE.
  - Otherwise go SCAN.
- SCAN: one bit per cycle.
  - If d_r[idx]==0: idx-=1, stay.
  - If d_r[idx]==1: go MUL. The squaring for the leading bit is skipped since r==1.
- SQ: assert mul_start for one cycle with mul_a=mul_b=r, mul_mod=n_r; go WAIT_SQ.
- WAIT_SQ: on mul_done, r=mul_result. If d_r[idx] go MUL, else go NEXT.
- MUL: mul_start pulse with mul_a=r, mul_b=c_r; go WAIT_MUL.
- WAIT_MUL: on mul_done, r=mul_result; go NEXT.
- NEXT: if idx==0, m=r and go DONE. Else idx-=1, go SQ.
- Operand stability: mul_a, mul_b, mul_mod stay stable from the mul_start cycle until the mul_done cycle.
- Watchdog: wd clears on each mul_start and increments each WAIT_* cycle. When wd reaches TIMEOUT with no mul_done: m=0, error=1, go DONE.
- mul_done outside WAIT_* states is ignored.
- DONE (1 cycle): done=1, busy=1; return to IDLE. start is accepted again from the next cycle.
- Multiply count for d!=0: mults = popcount(d); squares = (index of MSB set) - 0 = msb(d).
- Latency for a fixed-latency-L multiplier: 1 (LOAD) + (WIDTH-1-msb) scan cycles + 1 + (mults+squares)*(L+1) + (WIDTH-1-... NEXT cycles = msb+1) + 1 (DONE).
- Arithmetic: the controller performs no arithmetic other than idx decrement and wd increment. All modular reduction is done in the multiplier. c ≥ n is legal; it is reduced by the first MUL.

Test Plan:
- n=33, d=7, c=31, multiplier model latency 3 -> done with m=4, error=0; exactly 5 mul_start pulses in order MUL, SQ, MUL, SQ, MUL.
- n=0xFFFFFFFF, d=0xFFFFFFFF, c=0xFFFFFFFF -> m=0, error=0; 63 mul_start pulses (32 MUL, 31 SQ).
- d=0, n=33 -> m=1 with no mul_start. n=1 -> m=0 with no mul_start. n=0 -> m=0, error=1 with no mul_start; each case gives done 2 cycles after start.
- Multiplier model never asserts mul_done, TIMEOUT=16 -> done with error=1, m=0 exactly 16 cycles after the first WAIT cycle. A following valid request (n=33, d=7, c=31) clears error and returns m=4.
- rst_n low for 1 cycle during WAIT_SQ of the n=33 run -> all outputs 0 next cycle, no done. A stale mul_done is ignored. A subsequent start completes with m=4.
- start pulsed again while busy (different operands) -> ignored; result matches the first request. Operands are checked stable between each mul_start and mul_done.

Source files
------------

// File: rtl/modexp_ctrl.sv
// modexp_ctrl: sequencer for RSA decryption m = c^d mod n by left-to-right
// binary square-and-multiply. It latches n/d/c on start and drives one shared
// external modular multiplier through a mul_start/mul_done handshake.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start                 one-cycle request, sampled only in IDLE
//   n, d, c               modulus, private exponent, ciphertext
//   busy                  high from the cycle after accepted start through done
//   done                  one-cycle pulse, m/error valid
//   error                 n==0 or multiplier timeout; held until next start
//   m                     result, held until next result
//   mul_start             one-cycle multiply launch
//   mul_a, mul_b, mul_mod multiplier operands, stable until mul_done
//   mul_done, mul_result  multiplier completion and (a*b) mod n
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for start
// LOAD     | trivial-case checks on latched n_r / d_r
// SCAN     | skip leading zero bits of d_r, one bit per cycle
// SQ       | launch r*r
// WAIT_SQ  | wait for square result
// MUL      | launch r*c
// WAIT_MUL | wait for multiply result
// NEXT     | step to next exponent bit or finish
// DONE     | done pulse
module modexp_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] c,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] m,
  output logic             mul_start,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  output logic [WIDTH-1:0] mul_mod,
  input  logic             mul_done,
  input  logic [WIDTH-1:0] mul_result
);

  localparam int IW = $clog2(WIDTH);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_SCAN, S_SQ, S_WAIT_SQ, S_MUL, S_WAIT_MUL, S_NEXT, S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] n_r, d_r, c_r, r;
  logic [IW-1:0]    idx;
  logic [WW-1:0]    wd;
  logic             d_bit;
  logic             wd_expired;

  assign d_bit = d_r[idx];
  // wd counts completed WAIT cycles; the TIMEOUT-th one without mul_done aborts
  assign wd_expired = (wd == WW'(TIMEOUT - 1)) && !mul_done;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:     if (start) state_nxt = S_LOAD;
      S_LOAD:     if (n_r == '0 || n_r == WIDTH'(1) || d_r == '0) state_nxt = S_DONE;
                  else state_nxt = S_SCAN;
      S_SCAN:     if (d_bit) state_nxt = S_MUL;
      S_SQ:       state_nxt = S_WAIT_SQ;
      S_WAIT_SQ:  if (mul_done)        state_nxt = d_bit ? S_MUL : S_NEXT;
                  else if (wd_expired) state_nxt = S_DONE;
      S_MUL:      state_nxt = S_WAIT_MUL;
      S_WAIT_MUL: if (mul_done)        state_nxt = S_NEXT;
                  else if (wd_expired) state_nxt = S_DONE;
      S_NEXT:     state_nxt = (idx == '0) ? S_DONE : S_SQ;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    mul_start = (state == S_SQ) || (state == S_MUL);
  end

  // Operands are loaded on the transition into SQ/MUL so they are already
  // valid in the mul_start cycle and untouched until the next launch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_r     <= '0;
      d_r     <= '0;
      c_r     <= '0;
      r       <= '0;
      idx     <= '0;
      wd      <= '0;
      m       <= '0;
      error   <= 1'b0;
      mul_a   <= '0;
      mul_b   <= '0;
      mul_mod <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            n_r     <= n;
            d_r     <= d;
            c_r     <= c;
            r       <= WIDTH'(1);
            idx     <= IW'(WIDTH - 1);
            error   <= 1'b0;
            mul_mod <= n;
          end
        end
        S_LOAD: begin
          if (n_r == '0) begin
            m     <= '0;
            error <= 1'b1;
          end else if (n_r == WIDTH'(1)) begin
            m <= '0;
          end else if (d_r == '0) begin
            m <= WIDTH'(1);
          end
        end
        S_SCAN: begin
          if (!d_bit) begin
            idx <= idx - 1'b1;
          end else begin
            // leading one: r is 1, so the square is skipped
            mul_a <= r;
            mul_b <= c_r;
          end
        end
        S_SQ, S_MUL: wd <= '0;
        S_WAIT_SQ: begin
          if (mul_done) begin
            r <= mul_result;
            if (d_bit) begin
              mul_a <= mul_result;
              mul_b <= c_r;
            end
          end else begin
            wd <= wd + 1'b1;
            if (wd_expired) begin
              m     <= '0;
              error <= 1'b1;
            end
          end
        end
        S_WAIT_MUL: begin
          if (mul_done) begin
            r <= mul_result;
          end else begin
            wd <= wd + 1'b1;
            if (wd_expired) begin
              m     <= '0;
              error <= 1'b1;
            end
          end
        end
        S_NEXT: begin
          if (idx == '0) begin
            m <= r;
          end else begin
            idx   <= idx - 1'b1;
            mul_a <= r;
            mul_b <= r;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_ctrl.sv
module tb_modexp_ctrl;
  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 16;
  localparam int L       = 3;   // multiplier model: mul_done in 3rd WAIT cycle

  logic              clk = 1'b0;
  logic              rst_n, start;
  logic [WIDTH-1:0]  n, d, c;
  logic              busy, done, error, mul_start;
  logic [WIDTH-1:0]  m, mul_a, mul_b, mul_mod;
  logic              mul_done = 1'b0;
  logic [WIDTH-1:0]  mul_result = '0;

  modexp_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n(n), .d(d), .c(c),
    .busy(busy), .done(done), .error(error), .m(m),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_mod(mul_mod),
    .mul_done(mul_done), .mul_result(mul_result)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_done   = 0;
  int n_pulse  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] m; logic err; int c0; int lat; } exp_t;
  typedef struct { logic [31:0] a; logic [31:0] b; } op_t;
  exp_t exp_q[$];
  op_t  op_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] ref_modexp(input logic [31:0] nn, input logic [31:0] dd,
                                             input logic [31:0] cc);
    logic [63:0] acc, base;
    if (nn == 0) return 32'd0;
    acc  = 64'd1 % 64'(nn);
    base = 64'(cc) % 64'(nn);
    for (int i = 0; i < 32; i++) begin
      if (dd[i]) acc = (acc * base) % 64'(nn);
      base = (base * base) % 64'(nn);
    end
    return acc[31:0];
  endfunction

  function automatic int msb_of(input logic [31:0] v);
    int r = 0;
    for (int i = 0; i < 32; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic int pop_of(input logic [31:0] v);
    int r = 0;
    for (int i = 0; i < 32; i++) if (v[i]) r++;
    return r;
  endfunction

  function automatic int lat_of(input logic [31:0] dd);
    int mb = msb_of(dd);
    return 1 + (31 - mb) + 1 + (pop_of(dd) + mb) * (L + 1) + (mb + 1) + 1;
  endfunction

  // Multiplier model: checks operand order against op_q and operand stability.
  logic        respond = 1'b1;
  logic        stab_en = 1'b1;
  logic        active  = 1'b0;
  int          mcnt    = 0;
  logic [31:0] ca, cb, cm, res;
  op_t         eop;

  always @(negedge clk) begin
    mul_done = 1'b0;
    if (active) begin
      if (stab_en) begin
        chk("mul_a stable", mul_a, ca);
        chk("mul_b stable", mul_b, cb);
        chk("mul_mod stable", mul_mod, cm);
      end
      mcnt++;
      if (mcnt == L) begin
        mul_done   = 1'b1;
        mul_result = res;
        active     = 1'b0;
      end
    end
    if (mul_start) begin
      n_pulse++;
      ca = mul_a; cb = mul_b; cm = mul_mod;
      res = (mul_mod == 0) ? 32'd0 : 32'((64'(mul_a) * 64'(mul_b)) % 64'(mul_mod));
      active = respond;
      mcnt   = 0;
      if (op_q.size() > 0) begin
        eop = op_q.pop_front();
        chk("op mul_a", mul_a, eop.a);
        chk("op mul_b", mul_b, eop.b);
      end
    end
  end

  // Result scoreboard
  exp_t ex;
  always @(negedge clk) begin
    if (done) begin
      n_done++;
      chk("done expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        chk("m", m, ex.m);
        chk("error", error, ex.err);
        chk("latency", 64'(cyc - ex.c0 + 1), 64'(ex.lat));
      end
    end
  end

  task automatic launch(input logic [31:0] nn, input logic [31:0] dd, input logic [31:0] cc,
                        input logic [31:0] em, input logic ee, input int lat);
    exp_t e;
    e.m = em; e.err = ee; e.c0 = cyc + 1; e.lat = lat;
    exp_q.push_back(e);
    n = nn; d = dd; c = cc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int base = n_done;
    int k = 0;
    while (n_done == base && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({tag, " done within budget"}, 64'(n_done != base), 64'd1);
    @(negedge clk);
    chk({tag, " busy low after"}, busy, 0);
  endtask

  task automatic push_ops_33_7_31();
    op_t o;
    o.a = 1;  o.b = 31; op_q.push_back(o);
    o.a = 31; o.b = 31; op_q.push_back(o);
    o.a = 4;  o.b = 31; op_q.push_back(o);
    o.a = 25; o.b = 25; op_q.push_back(o);
    o.a = 31; o.b = 31; op_q.push_back(o);
  endtask

  initial begin
    logic [31:0] xn [2];
    logic [31:0] xd [2];
    logic [31:0] xc [2];
    int k;
    xn[0] = 32'd1000003;    xd[0] = 32'h0001_2345; xc[0] = 32'hABCD_EF01;
    xn[1] = 32'hF123_4567;  xd[1] = 32'h8000_0001; xc[1] = 32'd5;

    rst_n = 1'b0; start = 1'b0; n = '0; d = '0; c = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst error", error, 0);
    chk("rst m", m, 0);
    chk("rst mul_start", mul_start, 0);
    chk("rst mul_a", mul_a, 0);
    chk("rst mul_b", mul_b, 0);
    chk("rst mul_mod", mul_mod, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // basic 31^7 mod 33
    push_ops_33_7_31();
    n_pulse = 0;
    launch(32'd33, 32'd7, 32'd31, 32'd4, 1'b0, 55);
    wait_done("t1", 200);
    chk("t1 pulses", n_pulse, 5);
    chk("t1 ops consumed", op_q.size(), 0);

    // all ones: c == n reduces to 0
    n_pulse = 0;
    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 287);
    wait_done("t2", 600);
    chk("t2 pulses", n_pulse, 63);

    // trivial cases
    n_pulse = 0;
    launch(32'd0, 32'd5, 32'd7, 32'd0, 1'b1, 2);
    wait_done("n0", 20);
    launch(32'd33, 32'd0, 32'd31, 32'd1, 1'b0, 2);
    wait_done("d0", 20);
    launch(32'd1, 32'd5, 32'd7, 32'd0, 1'b0, 2);
    wait_done("n1", 20);
    chk("trivial pulses", n_pulse, 0);

    // arbitrary operands against reference
    for (int i = 0; i < 2; i++) begin
      n_pulse = 0;
      launch(xn[i], xd[i], xc[i], ref_modexp(xn[i], xd[i], xc[i]), 1'b0, lat_of(xd[i]));
      wait_done("ref", 600);
      chk("ref pulses", n_pulse, pop_of(xd[i]) + msb_of(xd[i]));
    end

    // multiplier never answers
    respond = 1'b0;
    n_pulse = 0;
    launch(32'd33, 32'd7, 32'd31, 32'd0, 1'b1, 49);
    wait_done("timeout", 100);
    chk("timeout pulses", n_pulse, 1);
    respond = 1'b1;
    push_ops_33_7_31();
    launch(32'd33, 32'd7, 32'd31, 32'd4, 1'b0, 55);
    wait_done("after timeout", 200);

    // reset during WAIT_SQ; no done expected
    n_pulse = 0;
    n = 32'd33; d = 32'd7; c = 32'd31; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (n_pulse < 2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("rst-mid reached SQ", 64'(n_pulse >= 2), 64'd1);
    @(negedge clk);
    chk("rst-mid busy before", busy, 1);
    stab_en = 1'b0;
    rst_n   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst-mid busy", busy, 0);
    chk("rst-mid done", done, 0);
    chk("rst-mid error", error, 0);
    chk("rst-mid m", m, 0);
    chk("rst-mid mul_start", mul_start, 0);
    chk("rst-mid mul_a", mul_a, 0);
    chk("rst-mid mul_b", mul_b, 0);
    chk("rst-mid mul_mod", mul_mod, 0);
    k = n_done;
    repeat (8) @(negedge clk);
    chk("rst-mid no done", n_done, k);
    chk("rst-mid idle", busy, 0);
    stab_en = 1'b1;
    push_ops_33_7_31();
    launch(32'd33, 32'd7, 32'd31, 32'd4, 1'b0, 55);
    wait_done("after rst", 200);

    // start while busy is ignored
    n_pulse = 0;
    push_ops_33_7_31();
    launch(32'd33, 32'd7, 32'd31, 32'd4, 1'b0, 55);
    repeat (10) @(negedge clk);
    chk("busy mid-run", busy, 1);
    n = 32'd35; d = 32'd3; c = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy start", 200);
    chk("busy start pulses", n_pulse, 5);
    chk("scoreboard empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
